// File: rtl/div_core_arbiter_pkg.sv
// cva5_types: shared types for the divider-core arbiter.
//   div_arb_state_t : arbiter FSM states
//   rr_next()       : round-robin pointer advance with wrap
// Width-dependent types (request index, operand pair) depend on module
// parameters, so they are declared inside the modules that use them.
package cva5_types;

    typedef enum logic {
        IDLE,
        RUN
    } div_arb_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/div_core_arbiter_if.sv
// div_core_arbiter_if: requester-side and core-side signals of the shared
// divider arbiter.
//   req_*  : per-port start/operands in, busy/done/result out
//   core_* : start/operands to the divider core, done/result back
// Modports:
//   slave  : the arbiter's view
//   master : the view of the surrounding requesters and divider core
interface div_core_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 55
);
    logic [NUM_REQ-1:0]            req_start;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]            req_busy;
    logic [NUM_REQ-1:0]            req_done;
    logic [DATA_WIDTH-1:0]         req_quotient;
    logic [DATA_WIDTH-1:0]         req_remainder;
    logic                          core_start;
    logic [DATA_WIDTH-1:0]         core_dividend;
    logic [DATA_WIDTH-1:0]         core_divisor;
    logic                          core_done;
    logic [DATA_WIDTH-1:0]         core_quotient;
    logic [DATA_WIDTH-1:0]         core_remainder;

    modport slave (
        input  req_start, req_dividend, req_divisor,
        output req_busy, req_done, req_quotient, req_remainder,
        output core_start, core_dividend, core_divisor,
        input  core_done, core_quotient, core_remainder
    );

    modport master (
        output req_start, req_dividend, req_divisor,
        input  req_busy, req_done, req_quotient, req_remainder,
        input  core_start, core_dividend, core_divisor,
        output core_done, core_quotient, core_remainder
    );
endinterface

// File: rtl/div_core_arbiter_rr_select.sv
// div_rr_select: combinational round-robin pick.
//   req   : request vector
//   ptr   : highest-priority index this round
//   grant : first set request at/after ptr, wrapping to 0
//   any   : at least one request set
module div_rr_select #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] req_idx_t;

    // Two passes: first the indices at/after ptr, then the wrapped-around remainder.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= 32'(ptr))) begin
                any   = 1'b1;
                grant = req_idx_t'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any   = 1'b1;
                grant = req_idx_t'(i);
            end
        end
    end
endmodule

// File: rtl/div_core_arbiter.sv
// div_core_arbiter: shares one iterative unsigned divider core between
// NUM_REQ requesters with round-robin arbitration.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : div_core_arbiter_if.slave
//                req_start/req_dividend/req_divisor in, req_busy/req_done,
//                req_quotient/req_remainder out (result bus qualified by req_done);
//                core_start/core_dividend/core_divisor out,
//                core_done/core_quotient/core_remainder in.
// Each port owns a one-entry pending slot. The core runs one op at a time;
// results are registered and returned with a one-cycle req_done pulse.
// Build option: DIV_ARB_BYPASS_EN -- with the core idle and nothing pending,
// a start is forwarded to the core in the same cycle (lowest index wins).
module div_core_arbiter
    import cva5_types::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 55
) (
    input logic               clk,
    input logic               rst_n,
    div_core_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] req_idx_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] dividend;
        logic [DATA_WIDTH-1:0] divisor;
    } div_operands_t;

    div_arb_state_t        state_q, state_d;
    logic [NUM_REQ-1:0]    pend_valid_q;
    div_operands_t         pend_ops_q [NUM_REQ];
    div_operands_t         port_ops   [NUM_REQ];
    div_operands_t         run_ops_q, launch_ops;
    req_idx_t              owner_q, rr_ptr_q, pick_idx, launch_idx, byp_idx;
    logic                  pick_any, byp_any, launch, bypass_take;
    logic [DATA_WIDTH-1:0] quot_q, rem_q;
    logic [NUM_REQ-1:0]    done_q, busy, illegal_start;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            port_ops[i].dividend = bus.req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
            port_ops[i].divisor  = bus.req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    div_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req   (pend_valid_q),
        .ptr   (rr_ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

`ifdef DIV_ARB_BYPASS_EN
    always_comb begin
        byp_any = 1'b0;
        byp_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!byp_any && bus.req_start[i]) begin
                byp_any = 1'b1;
                byp_idx = req_idx_t'(i);
            end
        end
    end
`else
    assign byp_any = 1'b0;
    assign byp_idx = '0;
`endif

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        bypass_take = 1'b0;
        launch_idx  = pick_idx;
        launch_ops  = pend_ops_q[pick_idx];
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    launch  = 1'b1;
                    state_d = RUN;
                end else if (byp_any) begin
                    launch      = 1'b1;
                    bypass_take = 1'b1;
                    launch_idx  = byp_idx;
                    launch_ops  = port_ops[byp_idx];
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (bus.core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = '0;
        illegal_start = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            busy[i] = pend_valid_q[i] || (state_q == RUN && owner_q == req_idx_t'(i));
            // The owner may restart in the cycle its op completes; the start lands in its slot.
            illegal_start[i] = bus.req_start[i] && (pend_valid_q[i] ||
                (state_q == RUN && owner_q == req_idx_t'(i) && !bus.core_done));
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) illegal_start == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_valid_q <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            run_ops_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            done_q       <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                pend_ops_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            if (launch) begin
                owner_q   <= launch_idx;
                run_ops_q <= launch_ops;
                if (!bypass_take) begin
                    pend_valid_q[launch_idx] <= 1'b0;
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (bus.req_start[i] && !(bypass_take && launch_idx == req_idx_t'(i))) begin
                    pend_valid_q[i] <= 1'b1;
                    pend_ops_q[i]   <= port_ops[i];
                end
            end
            if (state_q == RUN && bus.core_done) begin
                quot_q          <= bus.core_quotient;
                rem_q           <= bus.core_remainder;
                done_q[owner_q] <= 1'b1;
                rr_ptr_q        <= req_idx_t'(rr_next(32'(owner_q), NUM_REQ));
            end
        end
    end

    // Operands come from the selected slot while launching, then from the
    // captured copy so they stay stable for the whole run.
    assign bus.core_start    = launch;
    assign bus.core_dividend = (state_q == RUN) ? run_ops_q.dividend : launch_ops.dividend;
    assign bus.core_divisor  = (state_q == RUN) ? run_ops_q.divisor  : launch_ops.divisor;
    assign bus.req_busy      = busy;
    assign bus.req_done      = done_q;
    assign bus.req_quotient  = quot_q;
    assign bus.req_remainder = rem_q;
endmodule

// File: tb/tb_div_core_arbiter.sv
module tb_div_core_arbiter;
    localparam int N = 2;
    localparam int W = 55;
`ifdef DIV_ARB_BYPASS_EN
    localparam int BYP_LAT = 0;
`else
    localparam int BYP_LAT = 1;
`endif

    logic clk, rst_n;
    div_core_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bif ();

    div_core_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp, n_fail, cyc;

    // Reference model: per-port pending flags, one running op, rr pointer.
    bit           m_pend [N];
    logic [W-1:0] m_dvd [N], m_dvs [N];
    bit           m_run;
    int           m_owner, m_ptr, m_done_port;
    logic [W-1:0] m_rdvd, m_rdvs, m_q, m_r;

    // Divider core behaviour (stimulus side).
    bit           c_busy;
    int           c_cnt, core_lat;
    logic [W-1:0] c_dvd, c_dvs;

    // Stimulus controls.
    logic [N-1:0] drv_start;
    logic [W-1:0] drv_dvd [N], drv_dvs [N];
    bit           stray;
    int           n_started [N];

    // Logs: grants from the model, completions observed on the DUT.
    int           g_port[$], g_cyc[$], d_port[$], d_cyc[$];
    logic [W-1:0] d_q[$], d_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            drv_dvd[i] = rnd_w();
            drv_dvs[i] = ($urandom_range(0, 3) == 0) ? (rnd_w() | 1) : W'($urandom_range(1, 1000));
        end
    endtask

    task automatic clear_logs();
        g_port.delete(); g_cyc.delete(); d_port.delete(); d_cyc.delete();
        d_q.delete(); d_r.delete();
        for (int i = 0; i < N; i++) n_started[i] = 0;
    endtask

    task automatic do_reset();
        bif.req_start = '0;
        bif.core_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bif.req_busy, 0);
        chk("rst_done", bif.req_done, 0);
        chk("rst_core_start", bif.core_start, 0);
        chk("rst_quot", bif.req_quotient, 0);
        chk("rst_rem", bif.req_remainder, 0);
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_run = 0; m_owner = 0; m_ptr = 0; m_done_port = -1; m_q = '0; m_r = '0;
        c_busy = 0; stray = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step();
        bit           core_done_now, e_launch, e_byp, allowed;
        int           e_idx;
        logic [N-1:0] e_busy, eff, e_done;
        logic [W-1:0] e_dvd, e_dvs;
        @(negedge clk);
        core_done_now = 0;
        if (c_busy) begin
            c_cnt--;
            if (c_cnt == 0) core_done_now = 1;
        end
        if (stray) core_done_now = 1;
        bif.core_done = core_done_now;
        if (core_done_now && c_busy) begin
            bif.core_quotient  = c_dvd / c_dvs;
            bif.core_remainder = c_dvd % c_dvs;
        end else begin
            bif.core_quotient  = rnd_w();
            bif.core_remainder = rnd_w();
        end
        for (int i = 0; i < N; i++) begin
            e_busy[i] = m_pend[i] || (m_run && m_owner == i);
            allowed = !e_busy[i] || (m_run && m_owner == i && core_done_now && !m_pend[i]);
            eff[i] = drv_start[i] && allowed;
            bif.req_dividend[i*W +: W] = drv_dvd[i];
            bif.req_divisor[i*W +: W]  = drv_dvs[i];
        end
        bif.req_start = eff;
        #1;
        e_launch = 0; e_byp = 0; e_idx = 0;
        if (!m_run) begin
            for (int k = 0; k < N; k++) begin
                if (!e_launch && m_pend[(m_ptr + k) % N]) begin
                    e_launch = 1;
                    e_idx = (m_ptr + k) % N;
                end
            end
`ifdef DIV_ARB_BYPASS_EN
            for (int i = 0; i < N; i++) begin
                if (!e_launch && eff[i]) begin
                    e_launch = 1; e_byp = 1; e_idx = i;
                end
            end
`endif
        end
        e_dvd = m_run ? m_rdvd : (e_byp ? drv_dvd[e_idx] : m_dvd[e_idx]);
        e_dvs = m_run ? m_rdvs : (e_byp ? drv_dvs[e_idx] : m_dvs[e_idx]);
        e_done = '0;
        if (m_done_port >= 0) e_done[m_done_port] = 1'b1;
        chk("core_start", bif.core_start, e_launch);
        chk("req_busy", bif.req_busy, e_busy);
        chk("req_done", bif.req_done, e_done);
        if (e_launch || m_run) begin
            chk("core_dividend", bif.core_dividend, e_dvd);
            chk("core_divisor", bif.core_divisor, e_dvs);
        end
        if (m_done_port >= 0) begin
            chk("req_quotient", bif.req_quotient, m_q);
            chk("req_remainder", bif.req_remainder, m_r);
        end
        for (int i = 0; i < N; i++) begin
            if (bif.req_done[i]) begin
                d_port.push_back(i); d_cyc.push_back(cyc);
                d_q.push_back(bif.req_quotient); d_r.push_back(bif.req_remainder);
            end
        end
        if (e_launch) begin
            g_port.push_back(e_idx); g_cyc.push_back(cyc);
        end
        if (core_done_now) c_busy = 0;
        if (bif.core_start) begin
            c_busy = 1;
            c_dvd = bif.core_dividend;
            c_dvs = bif.core_divisor;
            c_cnt = (core_lat > 0) ? core_lat : $urandom_range(1, 6);
        end
        m_done_port = -1;
        if (m_run && core_done_now) begin
            m_done_port = m_owner;
            m_q = m_rdvd / m_rdvs;
            m_r = m_rdvd % m_rdvs;
            m_run = 0;
            m_ptr = (m_owner + 1) % N;
        end
        if (e_launch) begin
            m_run = 1; m_owner = e_idx; m_rdvd = e_dvd; m_rdvs = e_dvs;
            if (!e_byp) m_pend[e_idx] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (eff[i]) begin
                n_started[i]++;
                if (!(e_byp && e_idx == i)) begin
                    m_pend[i] = 1; m_dvd[i] = drv_dvd[i]; m_dvs[i] = drv_dvs[i];
                end
            end
        end
        stray = 0;
        cyc++;
    endtask

    task automatic wait_done(input int count, input int budget);
        int b;
        b = 0;
        while (d_port.size() < count && b < budget) begin
            step();
            b++;
        end
        chk("wait_done", d_port.size() >= count, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, b, ones;
        n_cmp = 0; n_fail = 0; cyc = 0; core_lat = 0; drv_start = '0; stray = 0;
        bif.core_quotient = '0; bif.core_remainder = '0;
        bif.req_dividend = '0; bif.req_divisor = '0;
        for (int i = 0; i < N; i++) begin drv_dvd[i] = 1; drv_dvs[i] = 1; end

        // Single op port 0: 100/7 with a 3-cycle core.
        do_reset(); clear_logs();
        drv_dvd[0] = 100; drv_dvs[0] = 7; core_lat = 3;
        t0 = cyc; drv_start = 2'b01; step(); drv_start = '0;
        wait_done(1, 50);
        chk("t1_grant_port", g_port[0], 0);
        chk("t1_start_lat", g_cyc[0] - t0, BYP_LAT);
        chk("t1_done_port", d_port[0], 0);
        chk("t1_done_lat", d_cyc[0] - t0, BYP_LAT + 1 + 3);
        chk("t1_q", d_q[0], 14);
        chk("t1_r", d_r[0], 2);

        // Both ports start together: port 0 first, port 1 in the IDLE cycle after.
        do_reset(); clear_logs();
        drv_dvd[0] = 500; drv_dvs[0] = 9; drv_dvd[1] = 77; drv_dvs[1] = 10; core_lat = 2;
        drv_start = 2'b11; step(); drv_start = '0;
        wait_done(2, 60);
        chk("t2_first", g_port[0], 0);
        chk("t2_second", g_port[1], 1);
        chk("t2_no_bubble", g_cyc[1], d_cyc[0]);
        chk("t2_q0", d_q[0], 55);
        chk("t2_r0", d_r[0], 5);
        chk("t2_q1", d_q[1], 7);
        chk("t2_r1", d_r[1], 7);

        // Port 1 queues during port 0's run; port 0 restarts on its core_done.
        do_reset(); clear_logs();
        drv_dvd[0] = 100; drv_dvs[0] = 7; drv_dvd[1] = 1000; drv_dvs[1] = 33; core_lat = 4;
        drv_start = 2'b01; step(); drv_start = '0;
        step(); step();
        drv_start = 2'b10; step(); drv_start = '0;
        drv_dvd[0] = 300; drv_dvs[0] = 11;
        b = 0;
        while (n_started[0] < 2 && b < 40) begin
            drv_start = 2'b01; step(); b++;
        end
        drv_start = '0;
        chk("t3_restart", n_started[0], 2);
        wait_done(3, 80);
        chk("t3_g0", g_port[0], 0);
        chk("t3_g1", g_port[1], 1);
        chk("t3_g2", g_port[2], 0);
        chk("t3_q2", d_q[2], 27);
        chk("t3_r2", d_r[2], 3);

        // Fairness: both ports request continuously, 8 ops each.
        do_reset(); clear_logs(); core_lat = 0;
        b = 0;
        while (g_port.size() < 16 && b < 600) begin
            for (int i = 0; i < N; i++) drv_start[i] = (n_started[i] < 8);
            rnd_ops(); step(); b++;
        end
        drv_start = '0;
        wait_done(16, 200);
        for (int k = 0; k < 16; k++) chk("t4_grant_order", g_port[k], k % 2);
        ones = 0;
        foreach (d_port[k]) if (d_port[k] == 1) ones++;
        chk("t4_port1_served", ones, 8);

        // Reset during RUN, stray core_done afterwards, then a clean op.
        do_reset(); clear_logs(); core_lat = 10;
        rnd_ops(); drv_start = 2'b01; step(); drv_start = '0;
        step(); step();
        do_reset();
        stray = 1; step(); step(); step();
        chk("t5_no_done", d_port.size(), 0);
        drv_dvd[0] = 100; drv_dvs[0] = 7; core_lat = 2;
        drv_start = 2'b01; step(); drv_start = '0;
        wait_done(1, 40);
        chk("t5_q", d_q[0], 14);
        chk("t5_r", d_r[0], 2);

        // Idle start on port 1: forwarding latency depends on the build option.
        do_reset(); clear_logs();
        drv_dvd[1] = 1000; drv_dvs[1] = 33; core_lat = 3;
        t0 = cyc; drv_start = 2'b10; step(); drv_start = '0;
        wait_done(1, 40);
        chk("t6_port", g_port[0], 1);
        chk("t6_start_lat", g_cyc[0] - t0, BYP_LAT);
        chk("t6_q", d_q[0], 30);
        chk("t6_r", d_r[0], 10);

        // Random traffic.
        do_reset(); clear_logs(); core_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) drv_start[i] = ($urandom_range(0, 2) == 0);
            rnd_ops(); step();
        end
        drv_start = '0;
        b = 0;
        while ((m_run || m_pend[0] || m_pend[1]) && b < 300) begin
            step(); b++;
        end
        step(); step();
        chk("drain_busy", bif.req_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
